// File: rtl/controlador_estados.sv
// controlador_estados: turns raw player buttons into timed one-hot actions for the attribute controller
// Ports:
//   clk, rst_n                   clock and asynchronous active-low reset
//   btn_dormir/comer/aula        raw asynchronous buttons (sleep / eat / teach)
//   fome, sono, felicidade       current attribute values, unsigned 8-bit
//   morreu                       sticky death flag, same clock domain
//   estado                       one-hot action: 0000 idle, 0001 sleep, 0010 eat, 0100 teach, 1000 dead
//   ocupado                      high while an action is running
//   recusada                     one-cycle pulse when a press is rejected
module controlador_estados #(
    parameter int         DURACAO   = 64,
    parameter logic [7:0] MAX_ATRIB = 8'd100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_dormir,
    input  logic       btn_comer,
    input  logic       btn_aula,
    input  logic [7:0] fome,
    input  logic [7:0] sono,
    input  logic [7:0] felicidade,
    input  logic       morreu,
    output logic [3:0] estado,
    output logic       ocupado,
    output logic       recusada
);
    localparam int TW = $clog2(DURACAO);

    typedef enum logic [3:0] {
        OCIOSO     = 4'b0000,
        DORMINDO   = 4'b0001,
        COMENDO    = 4'b0010,
        DANDO_AULA = 4'b0100,
        MORTO      = 4'b1000
    } estado_t;

    estado_t         estado_q, estado_n, sel;
    logic [TW-1:0]   timer_q, timer_n;
    logic [2:0]      s1, s2, s3, ev;
    logic [7:0]      atr, sel_atr;
    logic            rec_n;

    // Bit 0 dormir, bit 1 comer, bit 2 aula. The event is registered so the
    // FSM reacts one edge after the rising edge is detected.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
            ev <= '0;
        end else begin
            s1 <= {btn_aula, btn_comer, btn_dormir};
            s2 <= s1;
            s3 <= s2;
            ev <= s2 & ~s3;
        end

    // Attribute governing the running action, and the one for the selected press
    assign atr     = estado_q == DORMINDO ? sono : estado_q == COMENDO ? fome : felicidade;
    assign sel     = ev[0] ? DORMINDO : ev[1] ? COMENDO : DANDO_AULA;
    assign sel_atr = ev[0] ? sono : ev[1] ? fome : felicidade;

    always_comb begin
        estado_n = estado_q;
        timer_n  = timer_q;
        rec_n    = 1'b0;
        if (morreu)
            estado_n = MORTO;
        else
            case (estado_q)
                OCIOSO:
                    if (|ev) begin
                        if (sel_atr >= MAX_ATRIB)
                            rec_n = 1'b1;
                        else begin
                            estado_n = sel;
                            timer_n  = TW'(DURACAO - 1);
                        end
                    end
                DORMINDO, COMENDO, DANDO_AULA: begin
                    // Presses during an action are refused but never alter its course
                    rec_n = |ev;
                    if (atr >= MAX_ATRIB || timer_q == '0)
                        estado_n = OCIOSO;
                    else
                        timer_n = timer_q - TW'(1);
                end
                default: estado_n = MORTO;
            endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            estado_q <= OCIOSO;
            timer_q  <= '0;
            ocupado  <= 1'b0;
            recusada <= 1'b0;
        end else begin
            estado_q <= estado_n;
            timer_q  <= timer_n;
            ocupado  <= estado_n == DORMINDO || estado_n == COMENDO || estado_n == DANDO_AULA;
            recusada <= rec_n;
        end

    assign estado = estado_q;
endmodule

// File: tb/tb_controlador_estados.sv
// tb_controlador_estados: scoreboard bench for controlador_estados with DURACAO=8
module tb_controlador_estados;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_dormir, btn_comer, btn_aula;
    logic [7:0] fome, sono, felicidade;
    logic       morreu;
    logic [3:0] estado;
    logic       ocupado, recusada;

    controlador_estados #(.DURACAO(8), .MAX_ATRIB(8'd100)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_dormir(btn_dormir), .btn_comer(btn_comer), .btn_aula(btn_aula),
        .fome(fome), .sono(sono), .felicidade(felicidade), .morreu(morreu),
        .estado(estado), .ocupado(ocupado), .recusada(recusada)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        int         cyc;
        logic [3:0] e;
        logic       o;
        logic       r;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;
    logic [5:0] prev = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input string nm, input int c, input logic [3:0] e, input logic o, input logic r);
        exp_t x;
        x.nm = nm; x.cyc = c; x.e = e; x.o = o; x.r = r;
        q.push_back(x);
    endtask

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s got %b expected %b", nm, act, req);
        end
    endtask

    // Every change of the output triple must match the next queued expectation,
    // including the cycle on which it appears.
    always @(negedge clk) begin : monitor
        exp_t x;
        if (mon_en && {estado, ocupado, recusada} !== prev) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_change cyc=%0d got estado=%b ocupado=%b recusada=%b, none expected",
                         cyc, estado, ocupado, recusada);
            end else begin
                x = q.pop_front();
                if (x.cyc != cyc || x.e !== estado || x.o !== ocupado || x.r !== recusada) begin
                    fails++;
                    $display("FAIL %s got cyc=%0d estado=%b ocupado=%b recusada=%b expected cyc=%0d estado=%b ocupado=%b recusada=%b",
                             x.nm, cyc, estado, ocupado, recusada, x.cyc, x.e, x.o, x.r);
                end
            end
        end
        prev = {estado, ocupado, recusada};
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        rst_n = 1'b0;
        btn_dormir = 1'b0; btn_comer = 1'b0; btn_aula = 1'b0;
        fome = 8'd50; sono = 8'd50; felicidade = 8'd50; morreu = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_estado", estado, 4'b0000);
        chk("reset_ocupado", {3'b0, ocupado}, 4'b0000);
        chk("reset_recusada", {3'b0, recusada}, 4'b0000);
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // Sleep action of exactly 8 cycles
        c = cyc;
        push("dormir_start", c + 4, 4'b0001, 1'b1, 1'b0);
        push("dormir_end", c + 12, 4'b0000, 1'b0, 1'b0);
        btn_dormir = 1'b1;
        repeat (3) @(negedge clk);
        btn_dormir = 1'b0;
        repeat (12) @(negedge clk);

        // Eat refused because fome is full
        fome = 8'd100;
        c = cyc;
        push("comer_recusa_on", c + 4, 4'b0000, 1'b0, 1'b1);
        push("comer_recusa_off", c + 5, 4'b0000, 1'b0, 1'b0);
        btn_comer = 1'b1;
        repeat (3) @(negedge clk);
        btn_comer = 1'b0;
        repeat (6) @(negedge clk);
        fome = 8'd50;

        // Simultaneous dormir and aula: dormir wins silently
        c = cyc;
        push("simul_start", c + 4, 4'b0001, 1'b1, 1'b0);
        push("simul_end", c + 12, 4'b0000, 1'b0, 1'b0);
        btn_dormir = 1'b1; btn_aula = 1'b1;
        repeat (3) @(negedge clk);
        btn_dormir = 1'b0; btn_aula = 1'b0;
        repeat (12) @(negedge clk);

        // Eating: refused aula press, then early exit when fome becomes full
        fome = 8'd95;
        c = cyc;
        push("comer_start", c + 4, 4'b0010, 1'b1, 1'b0);
        push("comer_aula_recusa_on", c + 5, 4'b0010, 1'b1, 1'b1);
        push("comer_aula_recusa_off", c + 6, 4'b0010, 1'b1, 1'b0);
        push("comer_cheio_exit", c + 7, 4'b0000, 1'b0, 1'b0);
        btn_comer = 1'b1;
        @(negedge clk);
        btn_aula = 1'b1;
        repeat (2) @(negedge clk);
        btn_comer = 1'b0; btn_aula = 1'b0;
        repeat (3) @(negedge clk);
        fome = 8'd100;
        repeat (6) @(negedge clk);
        fome = 8'd50;

        // Death mid-teaching, presses ignored, async reset recovers
        c = cyc;
        push("aula_start", c + 4, 4'b0100, 1'b1, 1'b0);
        push("morto", c + 7, 4'b1000, 1'b0, 1'b0);
        btn_aula = 1'b1;
        repeat (3) @(negedge clk);
        btn_aula = 1'b0;
        repeat (3) @(negedge clk);
        morreu = 1'b1;
        repeat (3) @(negedge clk);
        btn_dormir = 1'b1;
        repeat (3) @(negedge clk);
        btn_dormir = 1'b0;
        repeat (6) @(negedge clk);
        c = cyc;
        push("reset_from_morto", c + 1, 4'b0000, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1 chk("async_reset_estado", estado, 4'b0000);
        morreu = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Held button: one action only, no re-trigger
        c = cyc;
        push("hold_start", c + 4, 4'b0100, 1'b1, 1'b0);
        push("hold_end", c + 12, 4'b0000, 1'b0, 1'b0);
        btn_aula = 1'b1;
        repeat (50) @(negedge clk);
        btn_aula = 1'b0;
        repeat (8) @(negedge clk);

        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
